// File: rtl/fpga_endpoint_uart_tx_pkg.sv
// Shared types and constants for the FPGA endpoint UART response serializer.
package fpga_endpoint_uart_tx_pkg;

  localparam int unsigned NUM_DATA_BYTES = 4;
  localparam int unsigned IDX_W          = 3;
  localparam logic [7:0]  STATUS_OK      = 8'h00;
  localparam logic [7:0]  STATUS_ERR     = 8'h01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  function automatic logic [7:0] status_byte(input logic err);
    return err ? STATUS_ERR : STATUS_OK;
  endfunction

  // XOR over the status byte and the four data bytes
  function automatic logic [7:0] frame_xor(input rsp_t r);
    return status_byte(r.err) ^ r.data[7:0] ^ r.data[15:8] ^ r.data[23:16] ^ r.data[31:24];
  endfunction

endpackage

// File: rtl/fpga_uart_tx_byte.sv
// 8N1 byte serializer: owns baud/bit counters and start/data/stop sequencing.
// The data byte is latched at the end of the start bit; byte_done pulses after each stop bit.
module fpga_uart_tx_byte
  import fpga_endpoint_uart_tx_pkg::*;
#(
  parameter int unsigned CLKDIV_COUNT = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       last,
  input  logic [7:0] byte_in,
  output logic       serial_out,
  output logic       ready,
  output logic       busy,
  output logic       byte_done
);

  localparam int unsigned     BAUD_W    = $clog2(CLKDIV_COUNT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKDIV_COUNT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              serial_d, ready_d, busy_d, byte_done_d;
  logic              baud_end_c;

  assign baud_end_c = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      serial_out <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      serial_out <= serial_d;
      ready      <= ready_d;
      busy       <= busy_d;
      byte_done  <= byte_done_d;
    end
  end

  // Next state plus counter/shift datapath; every bit boundary clears the baud counter
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start) state_d = START_BIT;
      end
      START_BIT: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          shift_d = byte_in;
          state_d = DATA_BITS;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA_BITS: begin
        if (baud_end_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP_BIT;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP_BIT: begin
        if (baud_end_c) begin
          baud_d  = '0;
          state_d = last ? IDLE : START_BIT;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered line has no extra lag
  always_comb begin
    serial_d    = 1'b1;
    ready_d     = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    byte_done_d = (state_q == STOP_BIT) && baud_end_c;
    case (state_d)
      START_BIT: serial_d = 1'b0;
      DATA_BITS: serial_d = shift_d[0];
      default:   serial_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpga_endpoint_uart_tx.sv
// Bus response serializer: status byte, 32-bit data little-endian, optional XOR checksum
// byte when FPGA_UART_TX_CHECKSUM_EN is defined.
module fpga_endpoint_uart_tx
  import fpga_endpoint_uart_tx_pkg::*;
#(
  parameter int unsigned FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        rsp_ready,
  output logic        serial_out,
  output logic        tx_busy
);

  localparam int unsigned CLKDIV_COUNT = FREQUENCY / BAUD_RATE;
`ifdef FPGA_UART_TX_CHECKSUM_EN
  localparam int unsigned NUM_FRAME_BYTES = NUM_DATA_BYTES + 2;
`else
  localparam int unsigned NUM_FRAME_BYTES = NUM_DATA_BYTES + 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAME_BYTES - 1);

  rsp_t             rsp_in_c;
  rsp_t             cap_q;
  logic [IDX_W-1:0] byte_idx_q;
  logic [7:0]       byte_c;
  logic             xfer_c;
  logic             last_c;
  logic             byte_done;

  assign xfer_c = rsp_valid && rsp_ready;
  assign last_c = (byte_idx_q == LAST_IDX);

  always_comb begin
    rsp_in_c      = '0;
    rsp_in_c.err  = rsp_err;
    rsp_in_c.data = rsp_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      cap_q <= '0;
    else if (xfer_c) cap_q <= rsp_in_c;
  end

`ifdef FPGA_UART_TX_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      chk_q <= '0;
    else if (xfer_c) chk_q <= frame_xor(rsp_in_c);
  end
`endif

  // Byte index advances after each stop bit and parks at zero between frames
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         byte_idx_q <= '0;
    else if (rsp_ready) byte_idx_q <= '0;
    else if (byte_done) byte_idx_q <= byte_idx_q + IDX_W'(1);
  end

  always_comb begin
    byte_c = status_byte(cap_q.err);
    case (byte_idx_q)
      IDX_W'(1): byte_c = cap_q.data[7:0];
      IDX_W'(2): byte_c = cap_q.data[15:8];
      IDX_W'(3): byte_c = cap_q.data[23:16];
      IDX_W'(4): byte_c = cap_q.data[31:24];
`ifdef FPGA_UART_TX_CHECKSUM_EN
      IDX_W'(5): byte_c = chk_q;
`endif
      default:   byte_c = status_byte(cap_q.err);
    endcase
  end

  fpga_uart_tx_byte #(
    .CLKDIV_COUNT(CLKDIV_COUNT)
  ) u_byte (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (xfer_c),
    .last      (last_c),
    .byte_in   (byte_c),
    .serial_out(serial_out),
    .ready     (rsp_ready),
    .busy      (tx_busy),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_fpga_endpoint_uart_tx.sv
// Directed bench for fpga_endpoint_uart_tx at 16 cycles per bit.
module tb_fpga_endpoint_uart_tx;

  localparam int CDIV = 16;
`ifdef FPGA_UART_TX_CHECKSUM_EN
  localparam int NFB = 6;
`else
  localparam int NFB = 5;
`endif
  localparam int FRAME_CYC = 10 * CDIV * NFB;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        rsp_ready;
  logic        serial_out;
  logic        tx_busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  fpga_endpoint_uart_tx #(
    .FREQUENCY(16),
    .BAUD_RATE(1)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .serial_out(serial_out),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wait for a start bit (checking the current sample first), then decode mid-bit
  task automatic rx_byte(output logic [7:0] d, output logic frame_ok, output logic to,
                         output int t_start);
    int n;
    d = '0; frame_ok = 1'b1; to = 1'b0; t_start = 0; n = 0;
    while (serial_out !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (serial_out !== 1'b0) begin
      to = 1'b1;
    end else begin
      t_start = cyc;
      repeat (CDIV / 2) @(negedge clk);
      if (serial_out !== 1'b0) frame_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CDIV) @(negedge clk);
        d[i] = serial_out;
      end
      repeat (CDIV) @(negedge clk);
      if (serial_out !== 1'b1) frame_ok = 1'b0;
    end
  endtask

  task automatic send_req(input logic [31:0] data, input logic err);
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = 32'hFFFF_FFFF;
    rsp_err   = 1'b0;
  endtask

  task automatic test_reset;
    logic active;
    n_rst = 1'b0;
    rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (serial_out !== 1'b1) begin n_bad++; $display("FAIL reset_serial: got %b want 1", serial_out); end
    n_cmp++; if (rsp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rsp_ready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_rst = 1'b1;
    active = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || rsp_ready !== 1'b1 || tx_busy !== 1'b0) active = 1'b1;
    end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_idle_100: activity=%b want 0", active); end
  endtask

  task automatic test_basic;
    logic [7:0] exp [6];
    logic [7:0] d;
    logic ok, to;
    int ts, t0, n;
    exp = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    n_cmp++; if (rsp_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_pre: got %b want 1", rsp_ready); end
    send_req(32'hDEADBEEF, 1'b0);
    t0 = cyc;
    n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", tx_busy); end
    n_cmp++; if (rsp_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_low: got %b want 0", rsp_ready); end
    for (int i = 0; i < NFB; i++) begin
      rx_byte(d, ok, to, ts);
      n_cmp++; if (to || d !== exp[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h (timeout=%b) want %h", i, d, to, exp[i]); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_framing%0d: got %b want 1", i, ok); end
    end
    n = 0;
    while (rsp_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (cyc - t0 !== FRAME_CYC) begin n_bad++; $display("FAIL basic_ready_low_cycles: got %0d want %0d", cyc - t0, FRAME_CYC); end
  endtask

  task automatic test_error;
    logic [7:0] exp [6];
    logic [7:0] d;
    logic ok, to;
    int ts;
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_req(32'h0, 1'b1);
    for (int i = 0; i < NFB; i++) begin
      rx_byte(d, ok, to, ts);
      n_cmp++; if (to || !ok || d !== exp[i]) begin n_bad++; $display("FAIL error_byte%0d: got %h (ok=%b timeout=%b) want %h", i, d, ok, to, exp[i]); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    logic [7:0] exp [6];
    logic [7:0] d;
    logic ok, to, active;
    int ts;
    exp = '{8'h00, 8'h96, 8'h0F, 8'hC3, 8'hA5, 8'hFF};
    send_req(32'hA5C3_0F96, 1'b0);
    for (int i = 0; i < NFB; i++) begin
      if (i == 2) send_req(32'h1234_5678, 1'b0);
      rx_byte(d, ok, to, ts);
      n_cmp++; if (to || !ok || d !== exp[i]) begin n_bad++; $display("FAIL busy_ignore_byte%0d: got %h (ok=%b timeout=%b) want %h", i, d, ok, to, exp[i]); end
    end
    active = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (serial_out !== 1'b1) active = 1'b1;
    end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL busy_ignore_no_second_frame: activity=%b want 0", active); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [12];
    logic [7:0] d;
    logic ok, to;
    int ts, ta, tb, n;
    exp = '{8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44,
            8'h01, 8'h88, 8'h77, 8'h66, 8'h55, 8'hCD};
    ta = 0; tb = 0;
    rsp_valid = 1'b1; rsp_data = 32'h1122_3344; rsp_err = 1'b0;
    @(negedge clk);
    rsp_data = 32'h5566_7788; rsp_err = 1'b1;
    for (int i = 0; i < NFB; i++) begin
      rx_byte(d, ok, to, ts);
      if (i == 0) ta = ts;
      n_cmp++; if (to || !ok || d !== exp[i]) begin n_bad++; $display("FAIL b2b_a_byte%0d: got %h (ok=%b timeout=%b) want %h", i, d, ok, to, exp[i]); end
    end
    n = 0;
    while (rsp_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (rsp_ready !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    for (int i = 0; i < NFB; i++) begin
      rx_byte(d, ok, to, ts);
      if (i == 0) tb = ts;
      n_cmp++; if (to || !ok || d !== exp[6+i]) begin n_bad++; $display("FAIL b2b_b_byte%0d: got %h (ok=%b timeout=%b) want %h", i, d, ok, to, exp[6+i]); end
    end
    n_cmp++; if (tb - ta !== FRAME_CYC + 1) begin n_bad++; $display("FAIL b2b_start_spacing: got %0d want %0d", tb - ta, FRAME_CYC + 1); end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp [6];
    logic [7:0] d;
    logic ok, to, active;
    int ts, n;
    exp = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_req(32'hDEADBEEF, 1'b0);
    rx_byte(d, ok, to, ts);
    rx_byte(d, ok, to, ts);
    n = 0;
    while (serial_out !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    n_cmp++; if (serial_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pre_low: got %b want 0", serial_out); end
    #2 n_rst = 1'b0;
    #1;
    n_cmp++; if (serial_out !== 1'b1) begin n_bad++; $display("FAIL rst_mid_serial: got %b want 1", serial_out); end
    n_cmp++; if (rsp_ready !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready_busy: got %b/%b want 1/0", rsp_ready, tx_busy); end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    active = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || rsp_ready !== 1'b1) active = 1'b1;
    end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_resume: activity=%b want 0", active); end
    send_req(32'hDEADBEEF, 1'b0);
    for (int i = 0; i < NFB; i++) begin
      rx_byte(d, ok, to, ts);
      n_cmp++; if (to || !ok || d !== exp[i]) begin n_bad++; $display("FAIL rst_mid_byte%0d: got %h (ok=%b timeout=%b) want %h", i, d, ok, to, exp[i]); end
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
